// File: rtl/icache_sa.sv
// icache_sa: set-associative L1 instruction cache.
//
// Each fetch returns one whole aligned line of 64-bit words. Each word also
// has a predecode length tag and a length-valid bit. Misses are refilled
// from L2 through a req/gnt handshake followed by LINE_WORDS data beats.
// D-cache store snoops invalidate matching lines. A snoop that hits the
// line currently being refilled poisons that refill.
//
// Optional feature (macro ICACHE_PERF_CNT_EN): adds registered 32-bit
// hit, miss and snoop-invalidate counters.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   fetch_req/addr       lookup request (word address), taken when fetch_ready
//   fetch_resp_valid     one-cycle response pulse, one cycle after the request
//   fetch_hit/data/len   hit flag, line words, predecode tags
//   fetch_len_valid      per-word tag valid
//   len_wr_en/addr/data  predecode tag write for a whole resident line
//   snoop_wr_en/addr     D-cache store; invalidates the matching line
//   l2_req/addr/gnt      refill request handshake (line-aligned address)
//   l2_rvalid/rdata      refill beats, in word order
//   perf_*_cnt           counters (ICACHE_PERF_CNT_EN only)
//
// state   | meaning
// IDLE    | accepting lookups, responds next cycle
// REQ     | l2_req raised, waiting for l2_gnt
// FILL    | collecting LINE_WORDS refill beats
// INSTALL | writing the refilled line into the victim way
module icache_sa #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_req,
  input  logic [63:0]             fetch_addr,
  output logic                    fetch_ready,
  output logic                    fetch_resp_valid,
  output logic                    fetch_hit,
  output logic [64*LINE_WORDS-1:0] fetch_data,
  output logic [64*LINE_WORDS-1:0] fetch_len,
  output logic [LINE_WORDS-1:0]   fetch_len_valid,
  input  logic                    len_wr_en,
  input  logic [63:0]             len_wr_addr,
  input  logic [64*LINE_WORDS-1:0] len_wr_data,
  input  logic                    snoop_wr_en,
  input  logic [63:0]             snoop_addr,
  output logic                    l2_req,
  output logic [63:0]             l2_addr,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]             perf_hit_cnt,
  output logic [31:0]             perf_miss_cnt,
  output logic [31:0]             perf_snoop_inv_cnt,
`endif
  input  logic                    l2_gnt,
  input  logic                    l2_rvalid,
  input  logic [63:0]             l2_rdata
);

  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDXW  = $clog2(SETS);
  localparam int TAGW  = 64 - OFF - IDXW;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LBITS = 64 * LINE_WORDS;

  typedef enum logic [1:0] {IDLE, REQ, FILL, INSTALL} state_t;
  state_t state, state_nx;

  logic                  valid     [WAYS][SETS];
  logic [LINE_WORDS-1:0] len_valid [WAYS][SETS];
  logic [TAGW-1:0]       tag_arr   [WAYS][SETS];
  logic [LBITS-1:0]      data_arr  [WAYS][SETS];
  logic [LBITS-1:0]      len_arr   [WAYS][SETS];
  logic [WW-1:0]         vptr      [SETS];

  logic [IDXW-1:0] f_idx, lw_idx, s_idx, fill_idx;
  logic [TAGW-1:0] f_tag, lw_tag, s_tag, fill_tag;
  logic [LBITS-1:0] fill_buf;
  logic [OFF-1:0]   beat_cnt;
  logic             poison;

  logic            hit_any, lw_hit;
  logic [WW-1:0]   hit_way, lw_way, victim;
  logic            victim_evict;
  logic [WAYS-1:0] sn_vec;
  logic            snoop_fill, poison_now, do_install;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[OFF-1:0], len_wr_addr[OFF-1:0], snoop_addr[OFF-1:0]};

  assign f_idx  = fetch_addr[OFF +: IDXW];
  assign f_tag  = fetch_addr[OFF+IDXW +: TAGW];
  assign lw_idx = len_wr_addr[OFF +: IDXW];
  assign lw_tag = len_wr_addr[OFF+IDXW +: TAGW];
  assign s_idx  = snoop_addr[OFF +: IDXW];
  assign s_tag  = snoop_addr[OFF+IDXW +: TAGW];

  // Descending loops so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    lw_hit  = 1'b0;
    lw_way  = '0;
    sn_vec  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (valid[w][f_idx] && tag_arr[w][f_idx] == f_tag) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (valid[w][lw_idx] && tag_arr[w][lw_idx] == lw_tag) begin
        lw_hit = 1'b1;
        lw_way = WW'(w);
      end
      sn_vec[w] = snoop_wr_en && valid[w][s_idx] && tag_arr[w][s_idx] == s_tag;
    end
  end

  always_comb begin
    victim       = vptr[fill_idx];
    victim_evict = 1'b1;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid[w][fill_idx]) begin
        victim       = WW'(w);
        victim_evict = 1'b0;
      end
    end
  end

  // A snoop landing in the INSTALL cycle itself must also suppress the install.
  assign snoop_fill = snoop_wr_en && s_idx == fill_idx && s_tag == fill_tag;
  assign poison_now = poison || snoop_fill;
  assign do_install = (state == INSTALL) && !poison_now;

  always_comb begin
    state_nx    = state;
    fetch_ready = 1'b0;
    l2_req      = 1'b0;
    case (state)
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req && !hit_any) state_nx = REQ;
      end
      REQ: begin
        l2_req = 1'b1;
        if (l2_gnt) state_nx = FILL;
      end
      FILL: begin
        if (l2_rvalid && beat_cnt == OFF'(LINE_WORDS-1)) state_nx = INSTALL;
      end
      INSTALL: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      fetch_resp_valid <= 1'b0;
      fetch_hit        <= 1'b0;
      fetch_data       <= '0;
      fetch_len        <= '0;
      fetch_len_valid  <= '0;
      l2_addr          <= '0;
      fill_idx         <= '0;
      fill_tag         <= '0;
      beat_cnt         <= '0;
      poison           <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        vptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid[w][s]     <= 1'b0;
          len_valid[w][s] <= '0;
        end
      end
    end else begin
      state            <= state_nx;
      fetch_resp_valid <= 1'b0;
      fetch_hit        <= 1'b0;

      if (fetch_req && fetch_ready) begin
        fetch_resp_valid <= 1'b1;
        fetch_hit        <= hit_any;
        fetch_data       <= hit_any ? data_arr[hit_way][f_idx]  : '0;
        fetch_len        <= hit_any ? len_arr[hit_way][f_idx]   : '0;
        fetch_len_valid  <= hit_any ? len_valid[hit_way][f_idx] : '0;
        if (!hit_any) begin
          l2_addr  <= {fetch_addr[63:OFF], OFF'(0)};
          fill_idx <= f_idx;
          fill_tag <= f_tag;
          beat_cnt <= '0;
          poison   <= 1'b0;
        end
      end

      if (state == FILL && l2_rvalid) beat_cnt <= beat_cnt + 1'b1;
      if ((state == REQ || state == FILL) && snoop_fill) poison <= 1'b1;

      if (len_wr_en && lw_hit) len_valid[lw_way][lw_idx] <= '1;

      if (do_install) begin
        valid[victim][fill_idx]     <= 1'b1;
        len_valid[victim][fill_idx] <= '0;
        if (victim_evict) begin
          if (victim == WW'(WAYS-1)) vptr[fill_idx] <= '0;
          else                       vptr[fill_idx] <= victim + 1'b1;
        end
      end

      // Last so a same-cycle snoop beats a tag write to the same line.
      for (int w = 0; w < WAYS; w++) begin
        if (sn_vec[w]) valid[w][s_idx] <= 1'b0;
      end
    end
  end

  // Payload arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (state == FILL && l2_rvalid) fill_buf[64*beat_cnt +: 64] <= l2_rdata;
    if (len_wr_en && lw_hit) len_arr[lw_way][lw_idx] <= len_wr_data;
    if (do_install) begin
      tag_arr[victim][fill_idx]  <= fill_tag;
      data_arr[victim][fill_idx] <= fill_buf;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hit_cnt       <= '0;
      perf_miss_cnt      <= '0;
      perf_snoop_inv_cnt <= '0;
    end else begin
      if (fetch_req && fetch_ready && hit_any)  perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      if (fetch_req && fetch_ready && !hit_any) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (|sn_vec) perf_snoop_inv_cnt <= perf_snoop_inv_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa.sv
module tb_icache_sa;
   localparam int WAYS = 2;
   localparam int SETS = 256;
   localparam int LW   = 4;

   logic clk = 1'b0;
   logic reset;
   logic fetch_req;
   logic [63:0] fetch_addr;
   logic fetch_ready, fetch_resp_valid, fetch_hit;
   logic [64*LW-1:0] fetch_data, fetch_len;
   logic [LW-1:0] fetch_len_valid;
   logic len_wr_en;
   logic [63:0] len_wr_addr;
   logic [64*LW-1:0] len_wr_data;
   logic snoop_wr_en;
   logic [63:0] snoop_addr;
   logic l2_req;
   logic [63:0] l2_addr;
   logic l2_gnt, l2_rvalid;
   logic [63:0] l2_rdata;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_snoop_inv_cnt;
`endif

   icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
      .fetch_resp_valid(fetch_resp_valid), .fetch_hit(fetch_hit),
      .fetch_data(fetch_data), .fetch_len(fetch_len), .fetch_len_valid(fetch_len_valid),
      .len_wr_en(len_wr_en), .len_wr_addr(len_wr_addr), .len_wr_data(len_wr_data),
      .snoop_wr_en(snoop_wr_en), .snoop_addr(snoop_addr),
      .l2_req(l2_req), .l2_addr(l2_addr),
`ifdef ICACHE_PERF_CNT_EN
      .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt),
      .perf_snoop_inv_cnt(perf_snoop_inv_cnt),
`endif
      .l2_gnt(l2_gnt), .l2_rvalid(l2_rvalid), .l2_rdata(l2_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic fail(input string name, input logic [64*LW-1:0] obs, input logic [64*LW-1:0] exp);
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
   endtask

   bit          mv  [WAYS][SETS];
   logic [63:0] mt  [WAYS][SETS];
   logic [63:0] md  [WAYS][SETS][LW];
   logic [63:0] ml  [WAYS][SETS][LW];
   bit          mlv [WAYS][SETS];
   int          mp  [SETS];
   logic [63:0] fill_words [LW];

   function automatic int set_of(logic [63:0] a);
      return int'((a / LW) % SETS);
   endfunction

   function automatic logic [63:0] tag_of(logic [63:0] a);
      return a / (LW * SETS);
   endfunction

   function automatic int m_find(logic [63:0] a);
      for (int w = 0; w < WAYS; w++)
         if (mv[w][set_of(a)] && mt[w][set_of(a)] == tag_of(a)) return w;
      return -1;
   endfunction

   task automatic m_reset();
      for (int s = 0; s < SETS; s++) begin
         mp[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            mv[w][s] = 0;
            mlv[w][s] = 0;
         end
      end
   endtask

   task automatic m_install(input logic [63:0] a);
      int s, v;
      s = set_of(a);
      v = -1;
      for (int w = 0; w < WAYS; w++)
         if (v < 0 && !mv[w][s]) v = w;
      if (v < 0) begin
         v = mp[s];
         mp[s] = (mp[s] + 1) % WAYS;
      end
      mv[v][s] = 1;
      mt[v][s] = tag_of(a);
      mlv[v][s] = 0;
      for (int i = 0; i < LW; i++) md[v][s][i] = fill_words[i];
   endtask

   task automatic m_snoop(input logic [63:0] a);
      int w;
      w = m_find(a);
      if (w >= 0) mv[w][set_of(a)] = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++; if (fetch_ready !== 1'b1) fail({tag, "_ready"}, fetch_ready, 1'b1);
      checks++; if (fetch_resp_valid !== 1'b0) fail({tag, "_rvalid"}, fetch_resp_valid, 1'b0);
      checks++; if (fetch_hit !== 1'b0) fail({tag, "_hit"}, fetch_hit, 1'b0);
      checks++; if (fetch_data !== {(64*LW){1'b0}}) fail({tag, "_data"}, fetch_data, '0);
      checks++; if (fetch_len !== {(64*LW){1'b0}}) fail({tag, "_len"}, fetch_len, '0);
      checks++; if (fetch_len_valid !== {LW{1'b0}}) fail({tag, "_lenv"}, fetch_len_valid, '0);
      checks++; if (l2_req !== 1'b0) fail({tag, "_l2req"}, l2_req, 1'b0);
      checks++; if (l2_addr !== 64'h0) fail({tag, "_l2addr"}, l2_addr, 64'h0);
   endtask

   task automatic step(input bit f_en, input logic [63:0] fa,
                       input bit l_en, input logic [63:0] la, input logic [64*LW-1:0] ld,
                       input bit s_en, input logic [63:0] sa, output bit missed);
      int w, lw;
      logic [64*LW-1:0] ed, el;
      logic [LW-1:0] ev;
      logic eh;
      @(negedge clk);
      fetch_req = f_en; fetch_addr = fa;
      len_wr_en = l_en; len_wr_addr = la; len_wr_data = ld;
      snoop_wr_en = s_en; snoop_addr = sa;
      @(posedge clk); #1;
      fetch_req = 0; len_wr_en = 0; snoop_wr_en = 0;
      missed = 0;
      if (f_en) begin
         w = m_find(fa);
         ed = '0; el = '0; ev = '0;
         if (w >= 0)
            for (int i = 0; i < LW; i++) begin
               ed[64*i +: 64] = md[w][set_of(fa)][i];
               el[64*i +: 64] = ml[w][set_of(fa)][i];
               ev[i] = mlv[w][set_of(fa)];
            end
         eh = (w >= 0);
         checks++; if (fetch_resp_valid !== 1'b1) fail("resp_valid", fetch_resp_valid, 1'b1);
         checks++; if (fetch_hit !== eh) fail("hit", fetch_hit, eh);
         checks++; if (fetch_data !== ed) fail("data", fetch_data, ed);
         checks++; if (fetch_len !== el) fail("len", fetch_len, el);
         checks++; if (fetch_len_valid !== ev) fail("len_valid", fetch_len_valid, ev);
         missed = (w < 0);
      end else begin
         checks++; if (fetch_resp_valid !== 1'b0) fail("resp_idle", fetch_resp_valid, 1'b0);
      end
      if (l_en) begin
         lw = m_find(la);
         if (lw >= 0) begin
            mlv[lw][set_of(la)] = 1;
            for (int i = 0; i < LW; i++) ml[lw][set_of(la)][i] = ld[64*i +: 64];
         end
      end
      if (s_en) m_snoop(sa);
   endtask

   task automatic fetch(input logic [63:0] a, output bit missed);
      step(1, a, 0, 64'h0, '0, 0, 64'h0, missed);
   endtask

   task automatic refill(input logic [63:0] a, input int gnt_delay, input bit do_snoop,
                         input logic [63:0] sa, input logic [63:0] base);
      logic [63:0] line;
      bit poisoned;
      line = a & ~64'(LW - 1);
      poisoned = 0;
      checks++; if (l2_req !== 1'b1) fail("req_up", l2_req, 1'b1);
      checks++; if (l2_addr !== line) fail("req_addr", l2_addr, line);
      checks++; if (fetch_ready !== 1'b0) fail("req_not_ready", fetch_ready, 1'b0);
      for (int i = 0; i < gnt_delay; i++) begin
         @(posedge clk); #1;
         checks++; if (l2_req !== 1'b1) fail("req_hold", l2_req, 1'b1);
         checks++; if (fetch_resp_valid !== 1'b0) fail("req_no_resp", fetch_resp_valid, 1'b0);
      end
      @(negedge clk); l2_gnt = 1;
      @(posedge clk); #1; l2_gnt = 0;
      checks++; if (l2_req !== 1'b0) fail("req_drop", l2_req, 1'b0);
      for (int i = 0; i < LW; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         @(negedge clk);
         fill_words[i] = (base != 0) ? base + 64'(i) : {$urandom, $urandom};
         l2_rvalid = 1; l2_rdata = fill_words[i];
         if (do_snoop && i == 1) begin snoop_wr_en = 1; snoop_addr = sa; end
         @(posedge clk); #1;
         l2_rvalid = 0; snoop_wr_en = 0;
         checks++; if (fetch_ready !== 1'b0) fail("fill_busy", fetch_ready, 1'b0);
         if (do_snoop && i == 1) begin
            if ((sa & ~64'(LW - 1)) == line) poisoned = 1;
            else m_snoop(sa);
         end
      end
      checks++; if (fetch_ready !== 1'b0) fail("install_busy", fetch_ready, 1'b0);
      @(posedge clk); #1;
      checks++; if (fetch_ready !== 1'b1) fail("install_done_ready", fetch_ready, 1'b1);
      if (!poisoned) m_install(a);
   endtask

   function automatic logic [63:0] rand_addr();
      int sets3 [3] = '{0, 1, 'h40};
      return 64'((($urandom_range(0, 3) * SETS) + sets3[$urandom_range(0, 2)]) * LW
                 + $urandom_range(0, LW - 1));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit m;
      logic [64*LW-1:0] tags;
      logic [64*LW-1:0] exp_line;
      reset = 1; fetch_req = 0; fetch_addr = 0; len_wr_en = 0; len_wr_addr = 0;
      len_wr_data = 0; snoop_wr_en = 0; snoop_addr = 0; l2_gnt = 0; l2_rvalid = 0; l2_rdata = 0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk); reset = 0;

      fetch(64'h100, m);
      checks++; if (fetch_hit !== 1'b0) fail("cold_miss", fetch_hit, 1'b0);
      refill(64'h100, 3, 0, 64'h0, 64'hA0);
      fetch(64'h102, m);
      exp_line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      checks++; if (fetch_hit !== 1'b1) fail("refill_hit", fetch_hit, 1'b1);
      checks++; if (fetch_data !== exp_line) fail("refill_data", fetch_data, exp_line);
      checks++; if (fetch_len_valid !== 4'b0000) fail("refill_lenv", fetch_len_valid, 4'b0000);

      tags = {64'd4, 64'd3, 64'd2, 64'd1};
      step(0, 0, 1, 64'h100, tags, 0, 0, m);
      fetch(64'h100, m);
      checks++; if (fetch_len !== tags) fail("len_tags", fetch_len, tags);
      checks++; if (fetch_len_valid !== 4'b1111) fail("len_tags_valid", fetch_len_valid, 4'b1111);
      step(0, 0, 1, 64'h900, ~tags, 0, 0, m);
      fetch(64'h100, m);
      checks++; if (fetch_len !== tags) fail("len_unmapped", fetch_len, tags);

      fetch(64'h0, m);   refill(64'h0, 0, 0, 0, 0);
      fetch(64'h400, m); refill(64'h400, 1, 0, 0, 0);
      step(1, 64'h400, 0, 0, 0, 1, 64'h401, m);
      checks++; if (fetch_hit !== 1'b1) fail("snoop_same_cycle_hit", fetch_hit, 1'b1);
      fetch(64'h400, m);
      checks++; if (fetch_hit !== 1'b0) fail("snoop_next_cycle_miss", fetch_hit, 1'b0);
      refill(64'h400, 0, 0, 0, 0);

      fetch(64'h800, m); refill(64'h800, 0, 0, 0, 0);
      fetch(64'hC00, m); refill(64'hC00, 2, 0, 0, 0);
      fetch(64'h0, m);
      checks++; if (fetch_hit !== 1'b0) fail("repl_0_evicted", fetch_hit, 1'b0);
      refill(64'h0, 0, 0, 0, 0);
      fetch(64'h800, m);
      checks++; if (fetch_hit !== 1'b0) fail("repl_800_evicted", fetch_hit, 1'b0);
      refill(64'h800, 0, 0, 0, 0);

      step(0, 0, 0, 0, 0, 1, 64'h100, m);
      fetch(64'h100, m);
      refill(64'h100, 0, 1, 64'h102, 0);
      fetch(64'h100, m);
      checks++; if (fetch_hit !== 1'b0) fail("poison_miss", fetch_hit, 1'b0);

      @(negedge clk); l2_gnt = 1;
      @(posedge clk); #1; l2_gnt = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); l2_rvalid = 1; l2_rdata = 64'hBAD0 + 64'(i);
         @(posedge clk); #1; l2_rvalid = 0;
      end
      @(negedge clk); reset = 1; l2_rvalid = 1;
      @(posedge clk); #1;
      check_reset_outputs("midfill_reset");
      m_reset();
      @(negedge clk); reset = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk); l2_rvalid = 0;
      #1;
      check_reset_outputs("stray_beats");
      fetch(64'h100, m);
      checks++; if (fetch_hit !== 1'b0) fail("after_reset_miss", fetch_hit, 1'b0);
      refill(64'h100, 0, 0, 0, 0);

      for (int it = 0; it < 300; it++) begin
         int op;
         logic [63:0] a;
         op = $urandom_range(0, 9);
         a = rand_addr();
         if (op < 6) begin
            step(1, a, ($urandom_range(0, 4) == 0), rand_addr(), {$urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 4) == 0), rand_addr(), m);
            if (m) refill(a, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), rand_addr(), 0);
         end else if (op < 8) begin
            step(0, 0, 1, a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom}, 0, 0, m);
         end else begin
            step(0, 0, 0, 0, 0, 1, a, m);
         end
      end

`ifdef ICACHE_PERF_CNT_EN
      @(negedge clk); reset = 1;
      @(posedge clk); #1;
      m_reset();
      checks++; if (perf_hit_cnt !== 32'd0) fail("perf_rst_hit", perf_hit_cnt, 32'd0);
      @(negedge clk); reset = 0;
      fetch(64'h2000, m); refill(64'h2000, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) fetch(64'h2000, m);
      fetch(64'h3000, m); refill(64'h3000, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 64'h2001, m);
      step(0, 0, 0, 0, 0, 1, 64'h5000, m);
      checks++; if (perf_hit_cnt !== 32'd3) fail("perf_hit", perf_hit_cnt, 32'd3);
      checks++; if (perf_miss_cnt !== 32'd2) fail("perf_miss", perf_miss_cnt, 32'd2);
      checks++; if (perf_snoop_inv_cnt !== 32'd1) fail("perf_snoop", perf_snoop_inv_cnt, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
